decodifica_hamming: RTL and testbench

- Hamming(15,11) single-error-correcting decoder; receive-side counterpart of the team's 15-bit Hamming encoder.
- Accepts a 15-bit codeword over a valid/ready handshake, computes the 4-bit syndrome, corrects any single-bit error and returns the 11 data bits.
- Two-stage registered pipeline with full backpressure; sits between the link/storage read path and the data consumer.

---
 rtl/decodifica_hamming.sv | 114 +++++++++++
 tb/tb_decodifica_hamming.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decodifica_hamming.sv
// decodifica_hamming: Hamming(15,11) single-error-correcting decoder, two-stage valid/ready pipeline.
// Define HAMMING_CONTADOR_EN to add the saturating corrected-word counter (limpa_contador/contador_erros).
module decodifica_hamming
`ifdef HAMMING_CONTADOR_EN
  #(parameter int CONT_LARGURA = 16)
`endif
(
  input  logic        clk,
  input  logic        rst,
  input  logic        entrada_valida,
  output logic        entrada_pronta,
  input  logic [14:0] entrada,
  output logic        saida_valida,
  input  logic        saida_pronta,
  output logic [10:0] saida,
  output logic [3:0]  sindrome,
  output logic        erro_corrigido
`ifdef HAMMING_CONTADOR_EN
  ,
  input  logic                    limpa_contador,
  output logic [CONT_LARGURA-1:0] contador_erros
`endif
);

  function automatic logic [3:0] calc_sindrome(input logic [14:0] c);
    logic [3:0] s;
    s[0] = c[0] ^ c[2] ^ c[4]  ^ c[6]  ^ c[8]  ^ c[10] ^ c[12] ^ c[14];
    s[1] = c[1] ^ c[2] ^ c[5]  ^ c[6]  ^ c[9]  ^ c[10] ^ c[13] ^ c[14];
    s[2] = c[3] ^ c[4] ^ c[5]  ^ c[6]  ^ c[11] ^ c[12] ^ c[13] ^ c[14];
    s[3] = ^c[14:7];
    return s;
  endfunction

  // A nonzero syndrome is the 1-based position of the flipped bit.
  function automatic logic [14:0] corrige(input logic [14:0] c, input logic [3:0] s);
    logic [14:0] r;
    r = c;
    if (s != 4'd0) r[s - 4'd1] = ~r[s - 4'd1];
    return r;
  endfunction

  function automatic logic [10:0] extrai(input logic [14:0] c);
    return {c[14:8], c[6:4], c[2]};
  endfunction

  logic        vld_p1, vld_p2;
  logic [14:0] cw_p1;
  logic [3:0]  sind_p1, sind_p2;
  logic [10:0] dado_p1, dado_p2;
  logic        erro_p2;
  logic        carrega_p1, carrega_p2;

  assign carrega_p2     = !vld_p2 || saida_pronta;
  assign carrega_p1     = !vld_p1 || carrega_p2;
  assign entrada_pronta = carrega_p1;

  // Stage S1: raw codeword
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      cw_p1  <= '0;
    end else if (carrega_p1) begin
      vld_p1 <= entrada_valida;
      if (entrada_valida) cw_p1 <= entrada;
    end
  end

  // Stage S1 -> S2: syndrome and single-bit correction
  assign sind_p1 = calc_sindrome(cw_p1);
  assign dado_p1 = extrai(corrige(cw_p1, sind_p1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p2  <= 1'b0;
      dado_p2 <= '0;
      sind_p2 <= '0;
      erro_p2 <= 1'b0;
    end else if (carrega_p2) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        dado_p2 <= dado_p1;
        sind_p2 <= sind_p1;
        erro_p2 <= (sind_p1 != 4'd0);
      end
    end
  end

  assign saida_valida   = vld_p2;
  assign saida          = dado_p2;
  assign sindrome       = sind_p2;
  assign erro_corrigido = erro_p2;

`ifdef HAMMING_CONTADOR_EN
  function automatic logic [CONT_LARGURA-1:0] incr_satura(input logic [CONT_LARGURA-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [CONT_LARGURA-1:0] contagem;

  // Clear has priority over a same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      contagem <= '0;
    end else if (limpa_contador) begin
      contagem <= '0;
    end else if (vld_p2 && saida_pronta && erro_p2) begin
      contagem <= incr_satura(contagem);
    end
  end

  assign contador_erros = contagem;
`endif

endmodule

// File: tb/tb_decodifica_hamming.sv
// tb_decodifica_hamming: scoreboard bench for the Hamming(15,11) decoder.
// Define HAMMING_CONTADOR_EN to also exercise the error counter with CONT_LARGURA=2.
module tb_decodifica_hamming;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        entrada_valida = 1'b0;
  logic        entrada_pronta;
  logic [14:0] entrada = '0;
  logic        saida_valida;
  logic        saida_pronta = 1'b1;
  logic [10:0] saida;
  logic [3:0]  sindrome;
  logic        erro_corrigido;
`ifdef HAMMING_CONTADOR_EN
  logic        limpa_contador = 1'b0;
  logic [1:0]  contador_erros;
`endif

  int n_asserts = 0;
  int n_falhas  = 0;
  int tentativas;

  // expected {dado, sindrome, erro} attached to the word on entrada
  logic [15:0] exp_atual = '0;
  logic [15:0] fila[$];

  always #5 clk = ~clk;

`ifdef HAMMING_CONTADOR_EN
  decodifica_hamming #(.CONT_LARGURA(2)) dut (
`else
  decodifica_hamming dut (
`endif
    .clk(clk), .rst(rst),
    .entrada_valida(entrada_valida), .entrada_pronta(entrada_pronta), .entrada(entrada),
    .saida_valida(saida_valida), .saida_pronta(saida_pronta), .saida(saida),
    .sindrome(sindrome), .erro_corrigido(erro_corrigido)
`ifdef HAMMING_CONTADOR_EN
    , .limpa_contador(limpa_contador), .contador_erros(contador_erros)
`endif
  );

  function automatic logic [14:0] codifica(input logic [10:0] d);
    logic [14:0] c;
    logic par;
    int j;
    c = '0;
    j = 0;
    for (int i = 0; i < 15; i++) begin
      if (((i + 1) & i) != 0) begin
        c[i] = d[j];
        j++;
      end
    end
    for (int k = 0; k < 4; k++) begin
      par = 1'b0;
      for (int i = 0; i < 15; i++)
        if ((((i + 1) >> k) & 1) == 1 && i != (1 << k) - 1) par ^= c[i];
      c[(1 << k) - 1] = par;
    end
    return c;
  endfunction

  task automatic monitor();
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        fila.delete();
      end else begin
        if (saida_valida && saida_pronta) begin
          n_asserts++;
          if (fila.size() == 0) begin
            n_falhas++;
            $display("FAIL scoreboard_extra: got %h/%h/%b, expected no word", saida, sindrome, erro_corrigido);
          end else begin
            e = fila.pop_front();
            if ({saida, sindrome, erro_corrigido} !== e) begin
              n_falhas++;
              $display("FAIL scoreboard_word: got %h/%h/%b, expected %h/%h/%b",
                       saida, sindrome, erro_corrigido, e[15:5], e[4:1], e[0]);
            end
          end
        end
        if (entrada_valida && entrada_pronta) fila.push_back(exp_atual);
      end
    end
  endtask

  // Called right after a rising edge; returns right after the edge that accepted the word.
  task automatic envia(input logic [14:0] cw, input logic [10:0] d, input logic [3:0] s);
    logic ok;
    entrada        = cw;
    exp_atual      = {d, s, (s != 4'd0)};
    entrada_valida = 1'b1;
    tentativas     = 0;
    ok             = 1'b0;
    while (!ok && tentativas < 50) begin
      @(negedge clk);
      ok = entrada_pronta;
      tentativas++;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      n_asserts++;
      n_falhas++;
      $display("FAIL envia_timeout: word %h not accepted after %0d cycles", cw, tentativas);
    end
  endtask

  task automatic espera_vazio(input string nome);
    int ciclos;
    ciclos = 0;
    entrada_valida = 1'b0;
    while (fila.size() != 0 && ciclos < 40) begin
      @(posedge clk);
      #1;
      ciclos++;
    end
    n_asserts++;
    if (fila.size() != 0) begin
      n_falhas++;
      $display("FAIL %s_drain: %0d words still pending, expected 0", nome, fila.size());
    end
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_asserts++;
    if ({saida_valida, saida, sindrome, erro_corrigido} !== 17'd0) begin
      n_falhas++;
      $display("FAIL reset_outputs: got v=%b %h/%h/%b, expected all zero", saida_valida, saida, sindrome, erro_corrigido);
    end
`ifdef HAMMING_CONTADOR_EN
    n_asserts++;
    if (contador_erros !== 2'd0) begin
      n_falhas++;
      $display("FAIL reset_contador: got %0d, expected 0", contador_erros);
    end
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_asserts++;
    if (entrada_pronta !== 1'b1) begin
      n_falhas++;
      $display("FAIL reset_pronta: got %b, expected 1", entrada_pronta);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_limpas();
    saida_pronta = 1'b1;
    envia(15'h0000, 11'h000, 4'h0);
    entrada_valida = 1'b0;
    @(negedge clk);
    n_asserts++;
    if (saida_valida !== 1'b0) begin
      n_falhas++;
      $display("FAIL latencia_cedo: saida_valida=%b, expected 0", saida_valida);
    end
    @(negedge clk);
    n_asserts++;
    if (saida_valida !== 1'b1 || saida !== 11'h000 || sindrome !== 4'h0 || erro_corrigido !== 1'b0) begin
      n_falhas++;
      $display("FAIL latencia_k1: got v=%b %h/%h/%b, expected 1 000/0/0", saida_valida, saida, sindrome, erro_corrigido);
    end
    @(posedge clk);
    #1;
    envia(15'h7FFF, 11'h7FF, 4'h0);
    espera_vazio("limpas");
    @(negedge clk);
    n_asserts++;
    if (saida_valida !== 1'b0) begin
      n_falhas++;
      $display("FAIL valida_cai: saida_valida=%b, expected 0", saida_valida);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_erros_fixos();
    envia(15'h7FFB, 11'h7FF, 4'h3);
    envia(15'h0080, 11'h000, 4'h8);
    espera_vazio("erros_fixos");
  endtask

  task automatic test_back_to_back();
    int extra;
    extra = 0;
    saida_pronta = 1'b1;
    for (int i = 0; i < 8; i++) begin
      envia(codifica(11'(i * 37 + 5)), 11'(i * 37 + 5), 4'h0);
      if (tentativas != 1) extra++;
    end
    espera_vazio("b2b");
    n_asserts++;
    if (extra != 0) begin
      n_falhas++;
      $display("FAIL b2b_throughput: %0d stalled words, expected 0", extra);
    end
  endtask

  task automatic test_varredura();
    saida_pronta = 1'b1;
    for (int d = 0; d < 2048; d++) begin
      for (int p = 1; p <= 15; p++) begin
        envia(codifica(11'(d)) ^ (15'(1) << (p - 1)), 11'(d), 4'(p));
      end
    end
    espera_vazio("varredura");
  endtask

  task automatic test_backpressure();
    logic [10:0] retida;
    saida_pronta = 1'b0;
    envia(codifica(11'h123), 11'h123, 4'h0);
    envia(codifica(11'h456) ^ 15'h0010, 11'h456, 4'h5);
    entrada        = codifica(11'h789);
    exp_atual      = {11'h789, 4'h0, 1'b0};
    entrada_valida = 1'b1;
    @(negedge clk);
    retida = saida;
    n_asserts++;
    if (entrada_pronta !== 1'b0) begin
      n_falhas++;
      $display("FAIL bp_pronta: got %b, expected 0 after 2 accepts", entrada_pronta);
    end
    n_asserts++;
    if (saida_valida !== 1'b1 || saida !== 11'h123) begin
      n_falhas++;
      $display("FAIL bp_saida: got v=%b %h, expected 1 123", saida_valida, saida);
    end
    repeat (3) @(negedge clk);
    n_asserts++;
    if (saida !== retida || entrada_pronta !== 1'b0) begin
      n_falhas++;
      $display("FAIL bp_estavel: got %h pronta=%b, expected %h pronta=0", saida, entrada_pronta, retida);
    end
    @(posedge clk);
    #1;
    saida_pronta = 1'b1;
    envia(codifica(11'h789), 11'h789, 4'h0);
    espera_vazio("bp");
  endtask

  task automatic test_reset_meio();
    saida_pronta = 1'b0;
    envia(codifica(11'h0AA), 11'h0AA, 4'h0);
    envia(codifica(11'h555), 11'h555, 4'h0);
    entrada_valida = 1'b0;
    rst = 1'b1;
    #1;
    n_asserts++;
    if (saida_valida !== 1'b0 || saida !== 11'h000) begin
      n_falhas++;
      $display("FAIL rst_meio_async: got v=%b %h, expected 0 000", saida_valida, saida);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    saida_pronta = 1'b1;
    repeat (4) begin
      @(negedge clk);
      n_asserts++;
      if (saida_valida !== 1'b0 || entrada_pronta !== 1'b1) begin
        n_falhas++;
        $display("FAIL rst_meio_stale: got v=%b pronta=%b, expected 0 1", saida_valida, entrada_pronta);
      end
    end
    @(posedge clk);
    #1;
  endtask

`ifdef HAMMING_CONTADOR_EN
  task automatic test_contador();
    saida_pronta = 1'b1;
    envia(15'h7FFB, 11'h7FF, 4'h3);
    espera_vazio("cont_um");
    n_asserts++;
    if (contador_erros !== 2'd1) begin
      n_falhas++;
      $display("FAIL cont_um: got %0d, expected 1", contador_erros);
    end
    for (int i = 0; i < 4; i++) envia(15'h0080, 11'h000, 4'h8);
    envia(15'h7FFF, 11'h7FF, 4'h0);
    espera_vazio("cont_sat");
    n_asserts++;
    if (contador_erros !== 2'd3) begin
      n_falhas++;
      $display("FAIL cont_satura: got %0d, expected 3", contador_erros);
    end
    saida_pronta = 1'b0;
    envia(15'h7FFB, 11'h7FF, 4'h3);
    entrada_valida = 1'b0;
    @(posedge clk);
    #1;
    limpa_contador = 1'b1;
    saida_pronta   = 1'b1;
    @(posedge clk);
    #1;
    limpa_contador = 1'b0;
    n_asserts++;
    if (contador_erros !== 2'd0) begin
      n_falhas++;
      $display("FAIL cont_limpa: got %0d, expected 0", contador_erros);
    end
    espera_vazio("cont_limpa");
  endtask
`endif

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_limpas();
    test_erros_fixos();
    test_back_to_back();
    test_backpressure();
    test_reset_meio();
    test_varredura();
`ifdef HAMMING_CONTADOR_EN
    test_contador();
`endif
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_falhas);
    $finish;
  end

endmodule
